// File: rtl/branch_pkg.sv
// Shared opcode constants, branch condition codes, the result bundle and immediate
// decoders for the branch resolve unit.
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Widest supported XLEN; narrower configurations use the low bits of each field.
  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_cond_e;

  typedef struct packed {
    logic                taken;
    logic [MAX_XLEN-1:0] target;
    logic [MAX_XLEN-1:0] link;
    logic                redirect;
    logic [MAX_XLEN-1:0] redirect_pc;
    logic                illegal;
  } br_res_t;

  // Bits above xlen are cleared so the value is a clean XLEN-wide number.
  function automatic logic [MAX_XLEN-1:0] fit(input logic [MAX_XLEN-1:0] v,
                                              input int unsigned xlen);
    logic [MAX_XLEN-1:0] r;
    r = v;
    if (xlen < MAX_XLEN) r[MAX_XLEN-1:32] = '0;
    return r;
  endfunction

  function automatic logic [MAX_XLEN-1:0] imm_b(input logic [31:0] instr,
                                                input int unsigned xlen);
    logic [MAX_XLEN-1:0] v;
    v = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    return fit(v, xlen);
  endfunction

  function automatic logic [MAX_XLEN-1:0] imm_j(input logic [31:0] instr,
                                                input int unsigned xlen);
    logic [MAX_XLEN-1:0] v;
    v = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return fit(v, xlen);
  endfunction

  function automatic logic [MAX_XLEN-1:0] imm_i(input logic [31:0] instr,
                                                input int unsigned xlen);
    logic [MAX_XLEN-1:0] v;
    v = {{52{instr[31]}}, instr[31:20]};
    return fit(v, xlen);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the six B-type conditions; funct3 010/011 are
// reported as illegal and never taken.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (br_cond_e'(funct3))
      BEQ:     taken = eq;
      BNE:     taken = !eq;
      BLT:     taken = lt_s;
      BGE:     taken = !lt_s;
      BLTU:    taken = lt_u;
      BGEU:    taken = !lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves B-type/JAL/JALR outcomes against the fetch prediction in one registered
// stage, with flush and a saturating mispredict counter.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter bit JALR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_redirect,
  output logic [XLEN-1:0]  out_redirect_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] mispredict_cnt
);

  // Handshake: a beat transfers on in_valid && in_ready; the result holds while
  // out_valid && !out_ready, and in_ready = !out_valid || out_ready.

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_bx;
  logic [XLEN-1:0] imm_jx;
  logic [XLEN-1:0] imm_ix;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] tgt_b;
  logic [XLEN-1:0] tgt_j;
  logic [XLEN-1:0] tgt_r;
  logic            cond_taken;
  logic            cond_illegal;

  logic            taken;
  logic            illegal;
  logic            is_ctrl;
  logic [XLEN-1:0] target;
  logic            redirect;
  br_res_t         res_d;
  br_res_t         res_q;
  logic            valid_q;
  logic            accept;
  logic            count_en;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_bx = XLEN'(imm_b(in_instr, XLEN));
  assign imm_jx = XLEN'(imm_j(in_instr, XLEN));
  assign imm_ix = XLEN'(imm_i(in_instr, XLEN));
  assign pc4    = in_pc + XLEN'(4);
  assign tgt_b  = in_pc + imm_bx;
  assign tgt_j  = in_pc + imm_jx;
  assign tgt_r  = (in_rs1 + imm_ix) & ~XLEN'(1);

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (funct3),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    is_ctrl = 1'b0;
    target  = pc4;
    case (opcode)
      OP_BRANCH: begin
        is_ctrl = 1'b1;
        taken   = cond_taken;
        illegal = cond_illegal;
        target  = tgt_b;
      end
      OP_JAL: begin
        is_ctrl = 1'b1;
        taken   = 1'b1;
        target  = tgt_j;
      end
      OP_JALR: begin
        if (JALR_EN) begin
          is_ctrl = 1'b1;
          taken   = 1'b1;
          target  = tgt_r;
        end
      end
      default: ;
    endcase
  end

  // Second term catches a correct taken prediction whose fetch path still followed pc+4.
  assign redirect = (taken != in_pred_taken) ||
                    (taken && in_pred_taken && is_ctrl && (target != pc4));

  always_comb begin
    res_d             = '0;
    res_d.taken       = taken;
    res_d.target      = MAX_XLEN'(target);
    res_d.link        = MAX_XLEN'(pc4);
    res_d.redirect    = redirect;
    res_d.redirect_pc = MAX_XLEN'(taken ? target : pc4);
    res_d.illegal     = illegal;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign count_en = valid_q && out_ready && res_q.redirect && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= res_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (count_en && (mispredict_cnt != {CNT_W{1'b1}})) begin
      mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

  generate
    if (XLEN < MAX_XLEN) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{res_q.target[MAX_XLEN-1:XLEN], res_q.link[MAX_XLEN-1:XLEN],
                           res_q.redirect_pc[MAX_XLEN-1:XLEN]};
    end
  endgenerate

  assign out_valid       = valid_q;
  assign out_taken       = res_q.taken;
  assign out_target      = res_q.target[XLEN-1:0];
  assign out_link        = res_q.link[XLEN-1:0];
  assign out_redirect    = res_q.redirect;
  assign out_redirect_pc = res_q.redirect_pc[XLEN-1:0];
  assign out_illegal     = res_q.illegal;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN=32, CNT_W=2) with hand-computed vectors.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic [XLEN-1:0]  in_rs1 = '0;
  logic [XLEN-1:0]  in_rs2 = '0;
  logic             in_pred_taken = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [XLEN-1:0]  out_link;
  logic             out_redirect;
  logic [XLEN-1:0]  out_redirect_pc;
  logic             out_illegal;
  logic [CNT_W-1:0] mispredict_cnt;

  int errors = 0;
  int checks = 0;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .JALR_EN(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_pred_taken   (in_pred_taken),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_taken       (out_taken),
    .out_target      (out_target),
    .out_link        (out_link),
    .out_redirect    (out_redirect),
    .out_redirect_pc (out_redirect_pc),
    .out_illegal     (out_illegal),
    .mispredict_cnt  (mispredict_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [31:0] imm);
    return {imm[11:0], 5'd0, 3'b000, 5'd0, 7'b1100111};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
    in_valid      = 1'b1;
    in_instr      = instr;
    in_pc         = pc;
    in_rs1        = rs1;
    in_rs2        = rs2;
    in_pred_taken = pred;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    flush     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- vector tables ----------------
  logic [2:0]  cond_f3  [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b000, 3'b010};
  logic        cond_tk  [7] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};
  logic        cond_il  [7] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1};

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, out_valid, mispredict_cnt} !== {1'b1, 1'b0, 2'd0}) begin
      $display("FAIL reset_idle: rdy/vld/cnt=%b/%b/%0d want 1/0/0", in_ready, out_valid, mispredict_cnt);
      errors++;
    end
    // one counted mispredict, then a stalled beat held when reset hits
    drive(enc_b(3'b000, 32'hFFFF_FFF8), 32'h100, 32'd5, 32'd5, 1'b0);
    step();
    idle();
    step();
    out_ready = 1'b0;
    drive(enc_j(32'h10), 32'h80, 32'd0, 32'd0, 1'b0);
    step();
    idle();
    checks++;
    if ({out_valid, mispredict_cnt} !== {1'b1, 2'd1}) begin
      $display("FAIL reset_pre: vld/cnt=%b/%0d want 1/1", out_valid, mispredict_cnt);
      errors++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, mispredict_cnt, out_target, out_redirect} !== {1'b0, 2'd0, 32'h0, 1'b0}) begin
      $display("FAIL reset_async: vld/cnt/tgt/rd=%b/%0d/%h/%b want 0/0/0/0",
               out_valid, mispredict_cnt, out_target, out_redirect);
      errors++;
    end
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_beq();
    do_reset();
    drive(enc_b(3'b000, 32'hFFFF_FFF8), 32'h100, 32'd5, 32'd5, 1'b0);
    step();
    idle();
    checks++;
    if ({out_valid, out_taken, out_redirect, out_illegal} !== 4'b1110 ||
        out_target !== 32'hF8 || out_redirect_pc !== 32'hF8 || out_link !== 32'h104) begin
      $display("FAIL beq: v/t/r/i=%b%b%b%b tgt=%h rpc=%h link=%h want 1110 f8 f8 104",
               out_valid, out_taken, out_redirect, out_illegal, out_target, out_redirect_pc, out_link);
      errors++;
    end
    checks++;
    if (mispredict_cnt !== 2'd0) begin
      $display("FAIL beq_cnt_early: cnt=%0d want 0", mispredict_cnt);
      errors++;
    end
    step();
    checks++;
    if ({out_valid, mispredict_cnt} !== {1'b0, 2'd1}) begin
      $display("FAIL beq_cnt: vld/cnt=%b/%0d want 0/1", out_valid, mispredict_cnt);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rpc;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(enc_b(cond_f3[i], 32'h10), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b0);
      step();
      exp_rpc = cond_tk[i] ? 32'h210 : 32'h204;
      checks++;
      if ({out_valid, out_taken, out_illegal, out_redirect} !== {1'b1, cond_tk[i], cond_il[i], cond_tk[i]} ||
          out_target !== 32'h210 || out_redirect_pc !== exp_rpc) begin
        $display("FAIL cond_f3_%b: v/t/i/r=%b%b%b%b tgt=%h rpc=%h want 1%b%b%b 210 %h",
                 cond_f3[i], out_valid, out_taken, out_illegal, out_redirect, out_target,
                 out_redirect_pc, cond_tk[i], cond_il[i], cond_tk[i], exp_rpc);
        errors++;
      end
    end
    idle();
    step();
  endtask

  task automatic test_jal();
    do_reset();
    drive(enc_j(32'h800), 32'h1000, 32'd0, 32'd0, 1'b0);
    step();
    checks++;
    if ({out_taken, out_redirect} !== 2'b11 || out_target !== 32'h1800 ||
        out_link !== 32'h1004 || out_redirect_pc !== 32'h1800) begin
      $display("FAIL jal: t/r=%b%b tgt=%h link=%h rpc=%h want 11 1800 1004 1800",
               out_taken, out_redirect, out_target, out_link, out_redirect_pc);
      errors++;
    end
    drive(enc_j(32'h8), 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1);
    step();
    checks++;
    if ({out_taken, out_redirect} !== 2'b11 || out_target !== 32'h4 || out_link !== 32'h0) begin
      $display("FAIL jal_wrap: t/r=%b%b tgt=%h link=%h want 11 4 0",
               out_taken, out_redirect, out_target, out_link);
      errors++;
    end
    drive(enc_j(32'h4), 32'h700, 32'd0, 32'd0, 1'b1);
    step();
    checks++;
    if ({out_taken, out_redirect} !== 2'b10 || out_redirect_pc !== 32'h704) begin
      $display("FAIL jal_fallthru: t/r=%b%b rpc=%h want 10 704", out_taken, out_redirect, out_redirect_pc);
      errors++;
    end
    drive(32'h0000_0013, 32'h300, 32'd0, 32'd0, 1'b1);
    step();
    checks++;
    if ({out_taken, out_redirect, out_illegal} !== 3'b010 || out_target !== 32'h304 ||
        out_redirect_pc !== 32'h304) begin
      $display("FAIL nonctrl_pred1: t/r/i=%b%b%b tgt=%h rpc=%h want 010 304 304",
               out_taken, out_redirect, out_illegal, out_target, out_redirect_pc);
      errors++;
    end
    drive(32'h0000_0013, 32'h300, 32'd0, 32'd0, 1'b0);
    step();
    idle();
    checks++;
    if ({out_taken, out_redirect} !== 2'b00) begin
      $display("FAIL nonctrl_pred0: t/r=%b%b want 00", out_taken, out_redirect);
      errors++;
    end
    step();
  endtask

  task automatic test_jalr();
    do_reset();
    drive(enc_jalr(32'h4), 32'h40, 32'h2001, 32'd0, 1'b1);
    step();
    idle();
    checks++;
    if ({out_taken, out_redirect} !== 2'b11 || out_target !== 32'h2004 ||
        out_link !== 32'h44 || out_redirect_pc !== 32'h2004) begin
      $display("FAIL jalr: t/r=%b%b tgt=%h link=%h rpc=%h want 11 2004 44 2004",
               out_taken, out_redirect, out_target, out_link, out_redirect_pc);
      errors++;
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(enc_j(32'h20), 32'h500, 32'd0, 32'd0, 1'b1);
    step();
    drive(32'h0000_0013, 32'h600, 32'd0, 32'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({in_ready, out_valid} !== 2'b01 || out_target !== 32'h520 || out_link !== 32'h504) begin
        $display("FAIL stall_%0d: rdy/vld=%b%b tgt=%h link=%h want 01 520 504",
                 c, in_ready, out_valid, out_target, out_link);
        errors++;
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_taken} !== 3'b111 || out_target !== 32'h520) begin
      $display("FAIL drain_a: rdy/vld/t=%b%b%b tgt=%h want 111 520", in_ready, out_valid, out_taken, out_target);
      errors++;
    end
    @(posedge clk);
    #1;
    idle();
    checks++;
    if ({out_valid, out_taken} !== 2'b10 || out_target !== 32'h604 || out_link !== 32'h604) begin
      $display("FAIL drain_b: vld/t=%b%b tgt=%h link=%h want 10 604 604", out_valid, out_taken, out_target, out_link);
      errors++;
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL drain_empty: vld=%b want 0", out_valid);
      errors++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1;
    drive(enc_b(3'b000, 32'hFFFF_FFF8), 32'h100, 32'd5, 32'd5, 1'b0);
    step();
    flush = 1'b0;
    idle();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_load: vld=%b want 0", out_valid);
      errors++;
    end
    out_ready = 1'b0;
    drive(enc_b(3'b000, 32'hFFFF_FFF8), 32'h100, 32'd5, 32'd5, 1'b0);
    step();
    idle();
    flush = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      $display("FAIL flush_ready: vld/rdy=%b%b want 10", out_valid, in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_hold: vld=%b want 0", out_valid);
      errors++;
    end
    out_ready = 1'b1;
    drive(enc_b(3'b000, 32'hFFFF_FFF8), 32'h100, 32'd5, 32'd5, 1'b0);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++;
    if ({out_valid, mispredict_cnt} !== {1'b0, 2'd0}) begin
      $display("FAIL flush_cnt: vld/cnt=%b/%0d want 0/0", out_valid, mispredict_cnt);
      errors++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(enc_b(3'b000, 32'hFFFF_FFF8), 32'h100, 32'd5, 32'd5, 1'b0);
      step();
      checks++;
      if (mispredict_cnt !== CNT_W'(k - 1)) begin
        $display("FAIL sat_step_%0d: cnt=%0d want %0d", k, mispredict_cnt, k - 1);
        errors++;
      end
    end
    idle();
    step();
    step();
    checks++;
    if (mispredict_cnt !== 2'd3) begin
      $display("FAIL sat_hold: cnt=%0d want 3", mispredict_cnt);
      errors++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_beq();
    test_back_to_back();
    test_jal();
    test_jalr();
    test_backpressure();
    test_flush();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
